// File: rtl/i4_mul_if.sv
// rtl/i4_mul_if.sv - operand/result bundle for the Q2.2 multiplier
interface i4_mul_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] P;
    logic       OV;

    // Operand source side
    modport master (
        output A,
        output B,
        input  P,
        input  OV
    );

    // Multiplier side
    modport slave (
        input  A,
        input  B,
        output P,
        output OV
    );
endinterface

// File: rtl/i4_mul.sv
// rtl/i4_mul.sv - signed Q2.2 multiplier, registered result, optional saturation via I4_MUL_SAT_EN
module i4_mul (
    input  logic     clk,
    input  logic     rst_n,
    i4_mul_if.slave  bus
);

    logic [7:0] full_prod;
    logic [7:0] pp_term;
    logic       pp_bit;
    logic       ov_next;
    logic [3:0] p_next;

    // Baugh-Wooley array: cross terms with exactly one sign bit are inverted,
    // and the constant 2^4 + 2^7 corrects the sum modulo 2^8.
    always_comb begin
        full_prod = 8'h90;
        pp_term   = '0;
        pp_bit    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp_bit = bus.A[j] & bus.B[i];
                if ((i == 3) != (j == 3)) begin
                    pp_bit = ~pp_bit;
                end
                pp_term        = '0;
                pp_term[i + j] = pp_bit;
                full_prod      = full_prod + pp_term;
            end
        end
    end

    // Rescale by truncating two LSBs; flag results whose top three bits disagree
    always_comb begin
        ov_next = !((full_prod[7] == full_prod[6]) && (full_prod[6] == full_prod[5]));
`ifdef I4_MUL_SAT_EN
        if (ov_next) begin
            p_next = full_prod[7] ? 4'b1000 : 4'b0111;
        end else begin
            p_next = full_prod[5:2];
        end
`else
        p_next = full_prod[5:2];
`endif
    end

    // Result register; reset clears the in-flight result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.P  <= 4'b0000;
            bus.OV <= 1'b0;
        end else begin
            bus.P  <= p_next;
            bus.OV <= ov_next;
        end
    end

endmodule

// File: tb/tb_i4_mul.sv
// tb/tb_i4_mul.sv - scoreboard bench for i4_mul against an arithmetic reference
module tb_i4_mul;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [4:0] exp_q[$];

    i4_mul_if bus();

    i4_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product, floor division by 4, range test, then wrap or clamp
    function automatic logic [4:0] ref_model(input logic [3:0] a, input logic [3:0] b);
        int f;
        int r;
        int p;
        logic ov;
        logic [31:0] pw;
        f  = int'($signed(a)) * int'($signed(b));
        r  = (f >= 0) ? (f / 4) : -((-f + 3) / 4);
        ov = (r < -8) || (r > 7);
        p  = r;
`ifdef I4_MUL_SAT_EN
        if (ov) p = (f > 0) ? 7 : -8;
`endif
        pw = p;
        return {ov, pw[3:0]};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got P=%0d OV=%0b, required P=%0d OV=%0b",
                     name, act[3:0], act[4], req[3:0], req[4]);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        exp_q.push_back(ref_model(a, b));
    endtask

    // Monitor: one result per edge while out of reset, compared against the queue head
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            logic [4:0] exp_v;
            exp_v = exp_q.pop_front();
            check("scoreboard", {bus.OV, bus.P}, exp_v);
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.A  = 4'd7;
        bus.B  = 4'd7;
        #1;
        check("reset_async", {bus.OV, bus.P}, 5'b0_0000);
        @(posedge clk);
        #1;
        check("reset_hold", {bus.OV, bus.P}, 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values: in-range, truncation, floor, overflow, corner
        drive(4'd4,  4'd4);
        drive(4'd2,  4'd3);
        drive(4'hE,  4'd3);
        drive(4'hF,  4'd1);
        drive(4'd7,  4'd7);
        drive(4'h8,  4'd7);
        drive(4'h8,  4'h8);
        drive(4'd7,  4'd7);

        // Reset mid-stream with an overflowing result on the outputs
        @(negedge clk);
        rst_n = 1'b0;
        bus.A = 4'd7;
        bus.B = 4'd7;
        exp_q.delete();
        #1;
        check("midreset_async", {bus.OV, bus.P}, 5'b0_0000);
        @(posedge clk);
        #1;
        check("midreset_hold", {bus.OV, bus.P}, 5'b0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep, one pair per clock
        for (int v = 0; v < 256; v++) begin
            logic [7:0] ba;
            ba = v[7:0];
            drive(ba[3:0], ba[7:4]);
        end

        // Random back-to-back pairs
        for (int k = 0; k < 200; k++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Drain with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
